// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial front end for bit-level pattern detectors. WIDTH-bit words
// arrive over a valid/ready handshake and leave one bit per clock on
// serial_bit. A one-word holding register lets the next word queue up behind
// the one being shifted, so consecutive words stream with no idle cycle.
//
// Parameters
//   WIDTH      word size in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset (0 = reset)
//   in_data       word to serialize, sampled only on an accept edge
//   in_valid      in_data is valid
//   in_ready      a word can be accepted (accept = in_valid & in_ready)
//   serial_bit    current output bit, 0 whenever serial_valid = 0
//   serial_valid  serial_bit carries a data bit this cycle
//   word_start    current bit is the first bit of a word
//   word_end      current bit is the last bit of a word
//   busy          shifter active or holding register full
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_bit,
  output logic             serial_valid,
  output logic             word_start,
  output logic             word_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] hold_reg_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             hold_full_q;

  logic [WIDTH-1:0] shreg_shifted_d;
  logic             accept;
  logic             last_bit;
  logic             out_bit;
  logic             shifting;

  // Shifted copy of the shift register: one position toward the output end,
  // zero-filled at the far end.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (MSB_FIRST) begin : g_msb
      if (gi == 0) begin : g_fill
        assign shreg_shifted_d[gi] = 1'b0;
      end else begin : g_move
        assign shreg_shifted_d[gi] = shreg_q[gi-1];
      end
    end else begin : g_lsb
      if (gi == WIDTH - 1) begin : g_fill
        assign shreg_shifted_d[gi] = 1'b0;
      end else begin : g_move
        assign shreg_shifted_d[gi] = shreg_q[gi+1];
      end
    end
  end

  if (MSB_FIRST) begin : g_out_msb
    assign out_bit = shreg_q[WIDTH-1];
  end else begin : g_out_lsb
    assign out_bit = shreg_q[0];
  end

  // in_ready depends only on reset and a register, never on in_valid/in_data.
  assign in_ready = reset & ~hold_full_q;
  assign accept   = in_valid & in_ready;
  assign shifting = (state_q == SHIFT);
  assign last_bit = (bit_cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_reg_q  <= '0;
      bit_cnt_q   <= '0;
      hold_full_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // The hold register is always empty in IDLE, so an accept goes
          // straight into the shifter.
          if (accept) begin
            shreg_q   <= in_data;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end

        SHIFT: begin
          if (!last_bit) begin
            shreg_q   <= shreg_shifted_d;
            bit_cnt_q <= bit_cnt_q + CW'(1);
            if (accept) begin
              hold_reg_q  <= in_data;
              hold_full_q <= 1'b1;
            end
          end else if (hold_full_q) begin
            // in_ready is low here, so no accept can collide with the reload.
            shreg_q     <= hold_reg_q;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
          end else if (accept) begin
            // Word offered on the last bit skips the hold register entirely.
            shreg_q   <= in_data;
            bit_cnt_q <= '0;
          end else begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // All serial outputs are decoded from registers and gated by the state, so
  // they read 0 whenever the block is idle or held in reset.
  assign serial_valid = shifting;
  assign serial_bit   = shifting & out_bit;
  assign word_start   = shifting & (bit_cnt_q == '0);
  assign word_end     = shifting & last_bit;
  assign busy         = shifting | hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       serial_bit;
  logic       serial_valid;
  logic       word_start;
  logic       word_end;
  logic       busy;

  logic [7:0] l_data;
  logic       l_valid;
  logic       l_ready;
  logic       l_bit;
  logic       l_svalid;
  logic       l_start;
  logic       l_end;
  logic       l_busy;

  int checks = 0;
  int errors = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .serial_bit(serial_bit), .serial_valid(serial_valid),
    .word_start(word_start), .word_end(word_end), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(l_data), .in_valid(l_valid),
    .in_ready(l_ready), .serial_bit(l_bit), .serial_valid(l_svalid),
    .word_start(l_start), .word_end(l_end), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs checked 1 time unit after
  // the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input int i, input logic exp_bit,
                           input logic exp_start, input logic exp_end);
    $display("%s bit %0d: serial_bit=%0b start=%0b end=%0b", tag, i, serial_bit, word_start, word_end);
    check({tag, "_valid"}, {31'd0, serial_valid}, 32'd1);
    check({tag, "_bit"},   {31'd0, serial_bit},   {31'd0, exp_bit});
    check({tag, "_start"}, {31'd0, word_start},   {31'd0, exp_start});
    check({tag, "_end"},   {31'd0, word_end},     {31'd0, exp_end});
  endtask

  initial begin
    logic [7:0]  w_a5;
    logic [23:0] b2b_stream;
    logic [7:0]  b2b_words [3];
    logic [15:0] byp_stream;
    logic [7:0]  w_55;
    int          nxt;
    logic        took;

    w_a5       = 8'b1010_0101;
    b2b_stream = 24'b00000001_10000000_11111111;
    b2b_words[0] = 8'h01; b2b_words[1] = 8'h80; b2b_words[2] = 8'hFF;
    byp_stream = 16'b00001111_11110000;
    w_55       = 8'b0101_0101;

    // ---------------- reset with in_valid high ----------------
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    l_valid  = 1'b0;
    l_data   = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("reset cycle %0d: outputs=%b", c, {in_ready, serial_bit, serial_valid, word_start, word_end, busy});
      check("rst_outputs", {26'd0, in_ready, serial_bit, serial_valid, word_start, word_end, busy}, 32'd0);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    $display("reset released: in_ready=%0b serial_valid=%0b busy=%0b", in_ready, serial_valid, busy);
    check("rel_ready", {31'd0, in_ready},     32'd1);
    check("rel_valid", {31'd0, serial_valid}, 32'd0);
    check("rel_busy",  {31'd0, busy},         32'd0);
    tick();
    check("rel_idle_after_edge", {31'd0, serial_valid}, 32'd0);

    // ---------------- single word 8'hA5, MSB first ----------------
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check_bit("single", i, w_a5[7-i], (i == 0), (i == 7));
      tick();
    end
    check("single_idle_valid", {31'd0, serial_valid}, 32'd0);
    check("single_idle_busy",  {31'd0, busy},         32'd0);
    check("single_idle_bit",   {31'd0, serial_bit},   32'd0);

    // ---------------- back-to-back 01, 80, FF ----------------
    in_data  = b2b_words[0];
    in_valid = 1'b1;
    tick();
    nxt = 1;
    for (int i = 0; i < 24; i++) begin
      in_valid = (nxt < 3);
      in_data  = (nxt < 3) ? b2b_words[nxt] : 8'h00;
      #0;
      check_bit("b2b", i, b2b_stream[23-i], (i % 8 == 0), (i % 8 == 7));
      // Hold is empty only on the first bit of each word once a word is queued,
      // and permanently after the last word has moved into the shifter.
      check("b2b_ready", {31'd0, in_ready}, {31'd0, ((i % 8) == 0) || (i >= 16)});
      check("b2b_busy",  {31'd0, busy},     32'd1);
      took = in_valid & in_ready;
      tick();
      if (took) nxt++;
    end
    in_valid = 1'b0;
    check("b2b_words_taken", nxt, 32'd3);
    check("b2b_end_valid", {31'd0, serial_valid}, 32'd0);

    // ---------------- bypass: 0F then F0 on the last bit ----------------
    in_data  = 8'h0F;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      in_valid = (i == 7);
      in_data  = (i == 7) ? 8'hF0 : 8'h00;
      #0;
      check_bit("bypass", i, byp_stream[15-i], (i % 8 == 0), (i % 8 == 7));
      check("bypass_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("bypass_end_valid", {31'd0, serial_valid}, 32'd0);
    check("bypass_end_busy",  {31'd0, busy},         32'd0);

    // ---------------- LSB-first instance: 8'h01 ----------------
    l_data  = 8'h01;
    l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      $display("lsb bit %0d: serial_bit=%0b start=%0b end=%0b", i, l_bit, l_start, l_end);
      check("lsb_valid", {31'd0, l_svalid}, 32'd1);
      check("lsb_bit",   {31'd0, l_bit},    {31'd0, (i == 0)});
      check("lsb_start", {31'd0, l_start},  {31'd0, (i == 0)});
      check("lsb_end",   {31'd0, l_end},    {31'd0, (i == 7)});
      tick();
    end
    check("lsb_idle", {31'd0, l_svalid}, 32'd0);

    // ---------------- reset mid-word with a held word ----------------
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h3C;  // goes into the hold register on the next edge
    for (int i = 0; i < 3; i++) begin
      check_bit("midrst", i, 1'b1, (i == 0), 1'b0);
      tick();
      in_valid = 1'b0;
    end
    check("midrst_hold_full_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_busy",            {31'd0, busy},     32'd1);
    reset = 1'b0;
    #1;
    $display("mid-word reset: outputs=%b", {in_ready, serial_bit, serial_valid, word_start, word_end, busy});
    check("midrst_outputs", {26'd0, in_ready, serial_bit, serial_valid, word_start, word_end, busy}, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, in_ready},     32'd1);
    check("post_rst_valid", {31'd0, serial_valid}, 32'd0);
    check("post_rst_busy",  {31'd0, busy},         32'd0);
    tick();
    check("post_rst_idle",  {31'd0, serial_valid}, 32'd0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_bit("after_rst", i, w_55[7-i], (i == 0), (i == 7));
      tick();
    end
    check("after_rst_idle", {31'd0, serial_valid}, 32'd0);
    check("after_rst_busy", {31'd0, busy},         32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
